// File: rtl/chu_ddfs_mix_core_if.sv
// rtl/chu_ddfs_mix_core_if.sv - slot register bus for the DDFS mixer core
interface chu_ddfs_mix_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_ddfs_mix_core.sv
// rtl/chu_ddfs_mix_core.sv - multi-channel DDFS oscillator with envelopes, mixer and delta-sigma DAC
// Per channel: phase accumulator -> waveform -> envelope-scaled product; products are summed, saturated, then dithered to 1 bit.
module chu_ddfs_mix_core #(
  parameter int PW  = 30,
  parameter int NCH = 4,
  parameter int ET  = 10
) (
  input  logic               clk,
  input  logic               reset,
  chu_ddfs_mix_core_if.slave bus,
  output logic signed [15:0] pcm_out,
  output logic               pdm_out,
  output logic [NCH-1:0]     sync_out
);
  typedef enum logic [1:0] {IDLE = 2'd0, ATTACK = 2'd1, SUSTAIN = 2'd2, RELEASE = 2'd3} env_state_e;

  logic               wr_en;
  logic [1:0]         ch_sel;
  logic [2:0]         reg_sel;
  logic [ET-1:0]      tick_q, tick_d;
  logic               tick;
  logic signed [16:0] prod_a [NCH];
  logic [31:0]        stat_a [4];
  logic signed [17:0] mix_sum;
  logic signed [15:0] pcm_q, pcm_d;
  logic [16:0]        acc_q, acc_d;
  logic               unused_bits;

  assign wr_en       = bus.cs & bus.write;
  assign ch_sel      = bus.addr[4:3];
  assign reg_sel     = bus.addr[2:0];
  assign tick        = &tick_q;
  assign unused_bits = ^{bus.read, bus.wr_data};

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [PW-1:0]      fccw_q, fccw_d, phase_q, phase_d;
    logic [1:0]         wave_q, wave_d;
    logic               gate_q, gate_d;
    logic [14:0]        target_q, target_d, rate_q, rate_d, level_q, level_d;
    env_state_e         state_q, state_d;
    logic signed [16:0] prod_q, prod_d;
    logic               sync_q, sync_d;
    logic               sel;
    logic [15:0]        p, up;
    logic [14:0]        dn;
    logic signed [15:0] wave_s;
    logic signed [32:0] prod_full;

    always_comb begin
      sel      = wr_en && (int'(ch_sel) == g);
      fccw_d   = fccw_q;
      wave_d   = wave_q;
      gate_d   = gate_q;
      target_d = target_q;
      rate_d   = rate_q;
      phase_d  = phase_q + fccw_q;
      sync_d   = phase_q[PW-1];
      if (sel) begin
        case (reg_sel)
          3'd0: fccw_d = bus.wr_data[PW-1:0];
          3'd1: begin
            wave_d = bus.wr_data[1:0];
            gate_d = bus.wr_data[2];
            if (bus.wr_data[3]) phase_d = '0;
          end
          3'd2: target_d = bus.wr_data[14:0];
          3'd3: rate_d = bus.wr_data[14:0];
          default: ;
        endcase
      end

      // Gate edges win over a coincident tick; the level only moves on ticks (or sustain tracking).
      up      = {1'b0, level_q} + {1'b0, rate_q};
      dn      = level_q - rate_q;
      state_d = state_q;
      level_d = level_q;
      case (state_q)
        IDLE: if (gate_q) state_d = ATTACK;
        ATTACK: begin
          if (!gate_q) state_d = RELEASE;
          else if (tick) begin
            if (up >= {1'b0, target_q}) begin
              level_d = target_q;
              state_d = SUSTAIN;
            end else begin
              level_d = up[14:0];
            end
          end
        end
        SUSTAIN: begin
          if (!gate_q) state_d = RELEASE;
          else if (target_q > level_q) state_d = ATTACK;
          else level_d = target_q;
        end
        RELEASE: begin
          if (gate_q) state_d = ATTACK;
          else if (tick) begin
            if (level_q <= rate_q) begin
              level_d = '0;
              state_d = IDLE;
            end else begin
              level_d = dn;
            end
          end
        end
      endcase

      p = phase_q[PW-1 -: 16];
      case (wave_q)
        2'd0:    wave_s = '0;
        2'd1:    wave_s = p[15] ? 16'sh8001 : 16'sh7FFF;
        2'd2:    wave_s = p ^ 16'h8000;
        default: wave_s = (p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0}) ^ 16'h8000;
      endcase
      prod_full = wave_s * $signed({2'b00, level_q});
      prod_d    = 17'(prod_full >>> 15);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        fccw_q   <= '0;
        phase_q  <= '0;
        wave_q   <= '0;
        gate_q   <= 1'b0;
        target_q <= 15'h7FFF;
        rate_q   <= 15'h0001;
        level_q  <= '0;
        state_q  <= IDLE;
        prod_q   <= '0;
        sync_q   <= 1'b0;
      end else begin
        fccw_q   <= fccw_d;
        phase_q  <= phase_d;
        wave_q   <= wave_d;
        gate_q   <= gate_d;
        target_q <= target_d;
        rate_q   <= rate_d;
        level_q  <= level_d;
        state_q  <= state_d;
        prod_q   <= prod_d;
        sync_q   <= sync_d;
      end
    end

    assign prod_a[g]   = prod_q;
    assign stat_a[g]   = {13'b0, state_q, 2'b00, level_q};
    assign sync_out[g] = sync_q;
  end

  for (genvar g = NCH; g < 4; g++) begin : g_pad
    assign stat_a[g] = '0;
  end

  always_comb begin
    tick_d  = tick_q + 1'b1;
    mix_sum = '0;
    for (int i = 0; i < NCH; i++) mix_sum = mix_sum + 18'(prod_a[i]);
    if (mix_sum > 18'sd32767)       pcm_d = 16'sh7FFF;
    else if (mix_sum < -18'sd32768) pcm_d = 16'sh8000;
    else                            pcm_d = mix_sum[15:0];
    acc_d = {1'b0, acc_q[15:0]} + {1'b0, pcm_q ^ 16'h8000};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q <= '0;
      pcm_q  <= '0;
      acc_q  <= '0;
    end else begin
      tick_q <= tick_d;
      pcm_q  <= pcm_d;
      acc_q  <= acc_d;
    end
  end

  assign pcm_out     = pcm_q;
  assign pdm_out     = acc_q[16];
  assign bus.rd_data = (reg_sel == 3'd5) ? stat_a[ch_sel] : {16'h0000, pcm_q};
endmodule

// File: doc/chu_ddfs_mix_core.md
CHU_DDFS_MIX_CORE -- requirements
Module: chu_ddfs_mix_core

Interface
REQ-001 SHALL have parameter PW, default 30, meaning phase accumulator width in bits (PW >= 16).
REQ-002 SHALL have parameter NCH, default 4, meaning number of oscillator channels (1..4).
REQ-003 SHALL have parameter ET, default 10, meaning that the envelope steps once every 2^ET clocks.
REQ-004 SHALL have ports clk, input, 1, system clock; reset, input, 1, asynchronous active-high reset; one clock domain only.
REQ-005 SHALL have slot ports cs, read, write (input, 1 each), addr (input, 5), wr_data (input, 32) and rd_data (output, 32).
REQ-006 SHALL have ports pcm_out (output, 16, signed mixed sample), pdm_out (output, 1, delta-sigma bit) and sync_out (output, NCH, per-channel phase MSB).

Function
REQ-007 SHALL decode addr[4:3] as channel index and addr[2:0] as register; writes to a channel index >= NCH are ignored.
REQ-008 SHALL write on cs & write with register map: 0 fccw[PW-1:0]; 1 ctrl[3:0] (bits1:0 wave, bit2 gate, bit3 phase clear); 2 target[14:0]; 3 rate[14:0].
REQ-009 SHALL drive rd_data as follows: for addr[2:0]==5, {13'b0, env_state[1:0], 2'b0, level[14:0]} of the addressed channel; otherwise {16'h0000, pcm_out}.
REQ-010 SHALL update each channel phase as phase <= phase + fccw every clock, modulo 2^PW; a newly written fccw is used from the next clock.
REQ-011 SHALL zero the phase on the clock after a ctrl write with bit3=1; bit3 is not stored.
REQ-012 SHALL use p = phase[PW-1:PW-16] to generate the wave (signed 16-bit): mode 0 off (0); 1 square (p[15] ? 16'h8001 : 16'h7FFF); 2 saw (p ^ 16'h8000); 3 triangle ((p[15] ? ~{p[14:0],1'b0} : {p[14:0],1'b0}) ^ 16'h8000).
REQ-013 SHALL assert an envelope tick for one clock every 2^ET clocks from a free-running ET-bit counter shared by all channels.
REQ-014 SHALL implement a per-channel envelope FSM with states IDLE=0, ATTACK=1, SUSTAIN=2 and RELEASE=3.
REQ-015 SHALL make the FSM move IDLE or RELEASE -> ATTACK on the clock after gate becomes 1, and ATTACK or SUSTAIN -> RELEASE on the clock after gate becomes 0.
REQ-016 SHALL, in ATTACK on each tick, set level to min(level+rate, target) and enter SUSTAIN when the result equals target.
REQ-017 SHALL, in RELEASE on each tick, set level to max(level-rate, 0) and enter IDLE when the result is 0.
REQ-018 SHALL make SUSTAIN track target: a lowered target is applied immediately, and a raised target re-enters ATTACK.
REQ-019 SHALL make the level hold when rate is 0; it never wraps, and computation uses 16-bit intermediates.
REQ-020 SHALL form each channel output as (wave * level) >>> 15 (signed 17x16 product, arithmetic shift), registered.
REQ-021 SHALL sum all channel outputs at 18-bit width, saturate to [-32768, 32767] and register the result into pcm_out.
REQ-022 SHALL give pcm_out a latency of 2 clocks from phase/level register to output (product stage, mix stage).
REQ-023 SHALL run the first-order delta-sigma DAC as a 17-bit accumulator: acc <= acc[15:0] + (pcm_out ^ 16'h8000), with pdm_out = acc[16] registered.
REQ-024 SHALL register sync_out[i] as phase[PW-1] of channel i.
REQ-025 SHALL give the FSM transition the gate change when a gate change coincides with a tick; the tick's level step still applies within the new state's rule on the next tick only.

Reset
REQ-026 SHALL clear, on reset, fccw, phase, wave mode, gate, level, the tick counter, the mix, the DAC accumulator, pcm_out, pdm_out and sync_out to 0.
REQ-027 SHALL set, on reset, target to 15'h7FFF and rate to 15'h0001, and force all FSMs to IDLE.
REQ-028 SHALL take effect immediately when reset is asserted mid-envelope or mid-write, and no write is completed.

Verification
REQ-029 SHALL cover: ch0 wave=2, fccw=2^(PW-4), gate=1, target=7FFF, rate=7FFF (ET=2) -> level 7FFF after one tick, and pcm_out repeats a 16-step saw of period 16 clocks.
REQ-030 SHALL cover: ch0 gate=1 with rate=0x1000, target=0x3000 -> level 1000, 2000, 3000, then SUSTAIN (state 2); gate=0 -> 2000, 1000, 0, then IDLE.
REQ-031 SHALL cover: 4 channels square at phase 0, level 7FFF -> sum 4*7FFE saturates, and pcm_out = 16'h7FFF.
REQ-032 SHALL cover: a ctrl write with bit3=1 on a running channel -> phase = 0 on the next clock, and sync_out[ch] = 0.
REQ-033 SHALL cover: pcm_out held at 0 -> pdm_out has a 50% duty cycle (alternating 1/0 after settling); pcm_out = 7FFF -> pdm_out is 1 on 65535 of 65536 clocks.
REQ-034 SHALL cover: reset asserted during ATTACK -> rd_data (addr 5) = 0 asynchronously; target reads 7FFF via its effect, and a write to channel index >= NCH changes nothing.
